// File: rtl/ram16k_bist.sv
// ram16k_bist: four-pass march-test sequencer (W0, R0, W1, R1) driving a RAM16K-style memory.
// Defining BIST_ERRCNT_EN adds a saturating error_count port and runs all four passes regardless of mismatches.
module ram16k_bist #(
  parameter int ADDR_BITS = 14,
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED = WIDTH'(16'h5A5A)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     ram_in,
  output logic [ADDR_BITS-1:0] ram_address,
  output logic                 ram_load,
  input  logic [WIDTH-1:0]     ram_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_BITS-1:0] fail_address,
  output logic [WIDTH-1:0]     fail_data
`ifdef BIST_ERRCNT_EN
  ,
  output logic [15:0]          error_count
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_W0   = 3'd1;
  localparam logic [2:0] S_R0   = 3'd2;
  localparam logic [2:0] S_W1   = 3'd3;
  localparam logic [2:0] S_R1   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [ADDR_BITS-1:0] ADDR_LAST = '1;

  logic [2:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]     wdata_q, wdata_d;
  logic                 load_q, load_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [ADDR_BITS-1:0] failAddr_q, failAddr_d;
  logic [WIDTH-1:0]     failData_q, failData_d;
  logic [WIDTH-1:0]     expected;
  logic                 mismatch;
  logic                 firstFail;
  logic                 stopRun;
  logic                 cleanRun;
  logic                 atLast;
  logic                 atFirst;
`ifdef BIST_ERRCNT_EN
  logic [15:0]          errCount_q, errCount_d;
`endif

  function automatic logic [WIDTH-1:0] pattern(input logic [ADDR_BITS-1:0] a);
    return WIDTH'(a) ^ SEED;
  endfunction

  // R1 reads back the inverted pattern written during W1; R0 reads the true pattern.
  always_comb begin
    expected = (state_q == S_R1) ? ~pattern(addr_q) : pattern(addr_q);
    mismatch = ((state_q == S_R0) || (state_q == S_R1)) && (ram_out != expected);
  end

  assign atLast  = (addr_q == ADDR_LAST);
  assign atFirst = (addr_q == '0);

`ifdef BIST_ERRCNT_EN
  assign stopRun   = 1'b0;
  assign firstFail = mismatch && (errCount_q == '0);
`else
  assign stopRun   = mismatch;
  assign firstFail = mismatch;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    load_d     = load_q;
    done_d     = done_q;
    pass_d     = pass_q;
    failAddr_d = failAddr_q;
    failData_d = failData_q;
`ifdef BIST_ERRCNT_EN
    errCount_d = errCount_q;
    if (mismatch && (errCount_q != 16'hFFFF)) begin
      errCount_d = errCount_q + 16'd1;
    end
    cleanRun = (errCount_d == '0);
`else
    cleanRun = 1'b1;
`endif

    if (firstFail) begin
      failAddr_d = addr_q;
      failData_d = ram_out;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_W0;
          addr_d     = '0;
          wdata_d    = pattern('0);
          load_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          failAddr_d = '0;
          failData_d = '0;
`ifdef BIST_ERRCNT_EN
          errCount_d = '0;
`endif
        end
      end
      S_W0: begin
        if (atLast) begin
          state_d = S_R0;
          addr_d  = '0;
          load_d  = 1'b0;
        end else begin
          addr_d  = addr_q + ADDR_BITS'(1);
          wdata_d = pattern(addr_q + ADDR_BITS'(1));
        end
      end
      S_R0: begin
        if (stopRun) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          load_d  = 1'b0;
        end else if (atLast) begin
          state_d = S_W1;
          addr_d  = '0;
          wdata_d = ~pattern('0);
          load_d  = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_BITS'(1);
        end
      end
      S_W1: begin
        // Descending read-back starts from the top so R1 can run straight down to address 0.
        if (atLast) begin
          state_d = S_R1;
          addr_d  = ADDR_LAST;
          load_d  = 1'b0;
        end else begin
          addr_d  = addr_q + ADDR_BITS'(1);
          wdata_d = ~pattern(addr_q + ADDR_BITS'(1));
        end
      end
      S_R1: begin
        if (stopRun) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          load_d  = 1'b0;
        end else if (atFirst) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = cleanRun;
          load_d  = 1'b0;
        end else begin
          addr_d = addr_q - ADDR_BITS'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        load_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      load_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      failAddr_q <= '0;
      failData_q <= '0;
`ifdef BIST_ERRCNT_EN
      errCount_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      load_q     <= load_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      failAddr_q <= failAddr_d;
      failData_q <= failData_d;
`ifdef BIST_ERRCNT_EN
      errCount_q <= errCount_d;
`endif
    end
  end

  assign ram_in       = wdata_q;
  assign ram_address  = addr_q;
  assign ram_load     = load_q;
  assign busy         = (state_q == S_W0) || (state_q == S_R0) ||
                        (state_q == S_W1) || (state_q == S_R1);
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail_address = failAddr_q;
  assign fail_data    = failData_q;
`ifdef BIST_ERRCNT_EN
  assign error_count  = errCount_q;
`endif

endmodule

// File: tb/tb_ram16k_bist.sv
// tb_ram16k_bist: march-test runs against an in-bench 16-word RAM with injectable stuck-at bits.
// Expected writes and run results come from an algorithmic model and are checked by scoreboard monitors.
`timescale 1ns/1ps
module tb_ram16k_bist;

  localparam int AB    = 4;
  localparam int DEPTH = 1 << AB;
`ifdef BIST_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  typedef struct {
    logic [AB-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  typedef struct {
    int            cycles;
    bit            pass;
    logic [AB-1:0] fa;
    logic [15:0]   fd;
    int            errs;
  } res_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          start;
  logic [15:0]   ram_in;
  logic [AB-1:0] ram_address;
  logic          ram_load;
  logic [15:0]   ram_out;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AB-1:0] fail_address;
  logic [15:0]   fail_data;
`ifdef BIST_ERRCNT_EN
  logic [15:0]   error_count;
`endif

  int   total = 0;
  int   bad = 0;
  wr_t  writeQ[$];
  res_t resultQ[$];
  bit   faultOn;
  int   faultAddr;
  int   faultBit;
  bit   faultVal;
  logic [15:0] mem [DEPTH];
  int   busyCount = 0;
  bit   doneSeen = 1'b0;

  always #5 clock = ~clock;

  ram16k_bist #(.ADDR_BITS(AB), .WIDTH(16), .SEED(16'h5A5A)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .ram_in(ram_in),
    .ram_address(ram_address),
    .ram_load(ram_load),
    .ram_out(ram_out),
    .busy(busy),
    .done(done),
    .pass(pass),
    .fail_address(fail_address),
    .fail_data(fail_data)
`ifdef BIST_ERRCNT_EN
    ,
    .error_count(error_count)
`endif
  );

  function automatic logic [15:0] pattern(input int a);
    return 16'(a) ^ 16'h5A5A;
  endfunction

  // A stuck bit forces the stored value at one address, whatever is written there.
  function automatic logic [15:0] faulty(input logic [AB-1:0] a, input logic [15:0] d);
    logic [15:0] r;
    r = d;
    if (faultOn && (int'(a) == faultAddr)) r[faultBit] = faultVal;
    return r;
  endfunction

  always @(posedge clock) begin
    if (ram_load) mem[ram_address] <= faulty(ram_address, ram_in);
  end
  assign ram_out = mem[ram_address];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic noteError(inout res_t r, inout bit stop, input int a, input logic [15:0] v);
    if (r.errs == 0) begin
      r.fa = AB'(a);
      r.fd = v;
    end
    r.errs++;
    if (!ERRCNT) stop = 1'b1;
  endtask

  // March test at the algorithm level: array of words, four loops, first error wins.
  task automatic modelRun();
    logic [15:0] m [DEPTH];
    res_t r;
    wr_t  w;
    bit   stop;
    r.cycles = 0;
    r.pass   = 1'b1;
    r.fa     = '0;
    r.fd     = '0;
    r.errs   = 0;
    stop     = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      w.addr = AB'(a);
      w.data = pattern(a);
      writeQ.push_back(w);
      m[a] = faulty(AB'(a), pattern(a));
      r.cycles++;
    end
    for (int a = 0; a < DEPTH && !stop; a++) begin
      r.cycles++;
      if (m[a] !== pattern(a)) noteError(r, stop, a, m[a]);
    end
    if (!stop) begin
      for (int a = 0; a < DEPTH; a++) begin
        w.addr = AB'(a);
        w.data = ~pattern(a);
        writeQ.push_back(w);
        m[a] = faulty(AB'(a), ~pattern(a));
        r.cycles++;
      end
      for (int a = DEPTH - 1; a >= 0 && !stop; a--) begin
        r.cycles++;
        if (m[a] !== ~pattern(a)) noteError(r, stop, a, m[a]);
      end
    end
    r.pass = (r.errs == 0);
    resultQ.push_back(r);
  endtask

  // Write monitor: every RAM write must match the next predicted write.
  always @(negedge clock) begin
    wr_t w;
    if (reset_n && ram_load) begin
      if (writeQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected write actual=addr %0h data %0h required=no write", ram_address, ram_in);
      end else begin
        w = writeQ.pop_front();
        checkOutput("write address", 32'(ram_address), 32'(w.addr));
        checkOutput("write data", 32'(ram_in), 32'(w.data));
      end
    end
  end

  // Result monitor: counts busy cycles and checks the outcome when done rises.
  always @(negedge clock) begin
    res_t r;
    if (!reset_n) begin
      busyCount = 0;
      doneSeen  = 1'b0;
    end else begin
      if (busy) busyCount++;
      if (done && !doneSeen) begin
        if (resultQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected done actual=done=1 required=no result pending");
        end else begin
          r = resultQ.pop_front();
          checkOutput("busy cycles", 32'(busyCount), 32'(r.cycles));
          checkOutput("pass", 32'(pass), 32'(r.pass));
          checkOutput("fail_address", 32'(fail_address), 32'(r.fa));
          checkOutput("fail_data", 32'(fail_data), 32'(r.fd));
`ifdef BIST_ERRCNT_EN
          checkOutput("error_count", 32'(error_count), 32'(r.errs));
`endif
        end
        busyCount = 0;
      end
      doneSeen = done;
    end
  end

  task automatic pulseStart();
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!done && n < 300);
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL done timeout actual=done 0 required=done 1 within 300 cycles");
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " ram_load"}, 32'(ram_load), 32'd0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
    checkOutput({tag, " pass"}, 32'(pass), 32'd0);
    checkOutput({tag, " ram_address"}, 32'(ram_address), 32'd0);
    checkOutput({tag, " ram_in"}, 32'(ram_in), 32'd0);
    checkOutput({tag, " fail_address"}, 32'(fail_address), 32'd0);
    checkOutput({tag, " fail_data"}, 32'(fail_data), 32'd0);
  endtask

  task automatic applyStimulus(input bit fOn, input int fAddr, input int fBit, input bit fVal,
                               input int extraAt);
    faultOn   = fOn;
    faultAddr = fAddr;
    faultBit  = fBit;
    faultVal  = fVal;
    modelRun();
    pulseStart();
    if (extraAt > 0) begin
      repeat (extraAt - 1) @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
    end
    waitDone();
    repeat (2) @(posedge clock);
  endtask

  // Reset lands in busy cycle k; writes already observed are k-1, capped at the 16 of W0.
  task automatic abortRun(input int k);
    int seen;
    faultOn = 1'b0;
    modelRun();
    pulseStart();
    repeat (k - 1) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    checkIdleOutputs("abort");
    seen = (k - 1 < DEPTH) ? k - 1 : DEPTH;
    checkOutput("abort writes left", 32'(writeQ.size()), 32'(2 * DEPTH - seen));
    writeQ.delete();
    resultQ.delete(resultQ.size() - 1);
    @(posedge clock);
    #2 reset_n = 1'b1;
    repeat (2) @(posedge clock);
  endtask

  task automatic heldStartRuns();
    faultOn = 1'b0;
    modelRun();
    modelRun();
    @(posedge clock);
    #1 start = 1'b1;
    waitDone();
    @(posedge clock);
    #1;
    waitDone();
    start = 1'b0;
    repeat (3) @(posedge clock);
  endtask

  initial begin
    start   = 1'b0;
    faultOn = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    #3 reset_n = 1'b0;
    #9;
    checkIdleOutputs("reset");
    @(posedge clock);
    #2 reset_n = 1'b1;
    repeat (2) @(posedge clock);

    applyStimulus(1'b0, 0, 0, 1'b0, 0);
    applyStimulus(1'b0, 0, 0, 1'b0, 10);
    applyStimulus(1'b1, 5, 0, 1'b0, 0);
    applyStimulus(1'b1, 2, 15, 1'b0, 0);
    abortRun(20);
    applyStimulus(1'b0, 0, 0, 1'b0, 0);
    abortRun(8);
    applyStimulus(1'b1, 9, 3, 1'b1, 0);
    heldStartRuns();

    for (int i = 0; i < 12; i++) begin
      bit fOn;
      int extra;
      fOn   = ($urandom_range(0, 3) != 0);
      extra = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 15)) : 0;
      applyStimulus(fOn, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 15)),
                    bit'($urandom_range(0, 1)), extra);
    end

    repeat (3) @(posedge clock);
    checkOutput("writes pending", 32'(writeQ.size()), 32'd0);
    checkOutput("results pending", 32'(resultQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
